// File: rtl/hs_bus_receiver.sv
// hs_bus_receiver: responder side of the four-phase req/ack handshake on the
// shared 64-bit bus. busReq is synchronised into clkB, the bus word is captured
// on the same edge busAck rises, and captured words are queued in a small FIFO
// that local logic drains over rxValid/rxReady.
// Optional feature macro: HS_RX_PARITY_EN adds busParity/parityErr (sticky
// even-parity check at capture).
module hs_bus_receiver #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic                      clkB,
  input  logic                      rst,
  input  logic [DW-1:0]             sharedBus,
  input  logic                      busReq,
  output logic                      busAck,
  output logic [DW-1:0]             rxData,
  output logic                      rxValid,
  input  logic                      rxReady,
  output logic [$clog2(DEPTH):0]    fifoLevel,
  output logic [CW-1:0]             rxCount
`ifdef HS_RX_PARITY_EN
  ,
  input  logic                      busParity,
  output logic                      parityErr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_REL = 1'b1;

  logic [0:0]    state;
  logic [0:0]    stateNext;
  logic          ackNext;
  logic          reqMeta;
  logic          reqS;
  logic          pushC;
  logic          popC;
  logic          fullC;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [DW-1:0] mem [DEPTH];

  // Full decision uses the pre-edge occupancy, so a same-edge pop never frees room.
  assign fullC   = (fifoLevel == LW'(DEPTH));
  assign rxValid = (fifoLevel != '0);
  assign popC    = rxValid && rxReady;
  assign rxData  = rxValid ? mem[rdPtr] : '0;

  // Two-flop synchroniser for the asynchronous request.
  always_ff @(posedge clkB) begin
    if (!rst) begin
      reqMeta <= 1'b0;
      reqS    <= 1'b0;
    end else begin
      reqMeta <= busReq;
      reqS    <= reqMeta;
    end
  end

  // Handshake state and registered acknowledge.
  always_ff @(posedge clkB) begin
    if (!rst) begin
      state  <= IDLE;
      busAck <= 1'b0;
    end else begin
      state  <= stateNext;
      busAck <= ackNext;
    end
  end

  // Next-state logic: one capture per request high phase, held off while full.
  always_comb begin
    stateNext = state;
    ackNext   = busAck;
    pushC     = 1'b0;
    case (state)
      IDLE: begin
        ackNext = 1'b0;
        if (reqS && !fullC) begin
          pushC     = 1'b1;
          ackNext   = 1'b1;
          stateNext = WAIT_REL;
        end
      end
      WAIT_REL: begin
        ackNext = 1'b1;
        if (!reqS) begin
          ackNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        ackNext   = 1'b0;
      end
    endcase
  end

  // FIFO pointers, occupancy and received-word counter.
  always_ff @(posedge clkB) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
      rxCount   <= '0;
    end else begin
      if (pushC) begin
        wrPtr   <= wrPtr + AW'(1);
        rxCount <= rxCount + CW'(1);
      end
      if (popC) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({pushC, popC})
        2'b10:   fifoLevel <= fifoLevel + LW'(1);
        2'b01:   fifoLevel <= fifoLevel - LW'(1);
        default: fifoLevel <= fifoLevel;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty since rxData is masked.
  always_ff @(posedge clkB) begin
    if (pushC) begin
      mem[wrPtr] <= sharedBus;
    end
  end

`ifdef HS_RX_PARITY_EN
  // Sticky even-parity error, evaluated only on captured words.
  always_ff @(posedge clkB) begin
    if (!rst) begin
      parityErr <= 1'b0;
    end else if (pushC && (^{sharedBus, busParity})) begin
      parityErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_bus_receiver.sv
// Directed self-checking bench for hs_bus_receiver (DW=64, DEPTH=4, CW=16).
// Inputs change and outputs are sampled on the falling edge of clkB.
module tb_hs_bus_receiver;

  logic        clkB;
  logic        rst;
  logic [63:0] sharedBus;
  logic        busReq;
  logic        busAck;
  logic [63:0] rxData;
  logic        rxValid;
  logic        rxReady;
  logic [2:0]  fifoLevel;
  logic [15:0] rxCount;
`ifdef HS_RX_PARITY_EN
  logic        busParity;
  logic        parityErr;
`endif

  int nChecks = 0;
  int nFails  = 0;

  hs_bus_receiver #(.DW(64), .DEPTH(4), .CW(16)) dut (
    .clkB      (clkB),
    .rst       (rst),
    .sharedBus (sharedBus),
    .busReq    (busReq),
    .busAck    (busAck),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .fifoLevel (fifoLevel),
    .rxCount   (rxCount)
`ifdef HS_RX_PARITY_EN
    ,
    .busParity (busParity),
    .parityErr (parityErr)
`endif
  );

  initial clkB = 1'b0;
  always #5 clkB = ~clkB;

  // Wait up to maxCycles falling edges for busAck to reach want.
  task automatic waitAck(input logic want, input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (!ok) begin
        @(negedge clkB);
        if (busAck === want) ok = 1'b1;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clkB);
    rst     = 1'b0;
    busReq  = 1'b0;
    rxReady = 1'b0;
    repeat (3) @(negedge clkB);
    rst = 1'b1;
    @(negedge clkB);
  endtask

  task automatic test_reset();
    @(negedge clkB);
    rst    = 1'b0;
    busReq = 1'b1;
    repeat (3) @(negedge clkB);
    nChecks++; if (busAck !== 1'b0) begin nFails++; $display("FAIL reset_ack: got %b expected 0", busAck); end
    nChecks++; if (rxValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b expected 0", rxValid); end
    nChecks++; if (fifoLevel !== 3'd0) begin nFails++; $display("FAIL reset_level: got %0d expected 0", fifoLevel); end
    nChecks++; if (rxCount !== 16'd0) begin nFails++; $display("FAIL reset_count: got %0d expected 0", rxCount); end
    nChecks++; if (rxData !== 64'd0) begin nFails++; $display("FAIL reset_data: got %h expected 0", rxData); end
    busReq = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clkB);
  endtask

  task automatic test_single_xfer();
    bit ok;
    applyReset();
    sharedBus = 64'hDEAD_BEEF_0123_4567;
    busReq    = 1'b1;
    waitAck(1'b1, 3, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL single_ack_rise: got %b expected 1 within 3 edges", busAck); end
    nChecks++; if (rxValid !== 1'b1) begin nFails++; $display("FAIL single_valid: got %b expected 1", rxValid); end
    nChecks++; if (rxData !== 64'hDEAD_BEEF_0123_4567) begin nFails++; $display("FAIL single_data: got %h expected deadbeef01234567", rxData); end
    busReq = 1'b0;
    waitAck(1'b0, 3, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL single_ack_fall: got %b expected 0 within 3 edges", busAck); end
    nChecks++; if (rxCount !== 16'd1) begin nFails++; $display("FAIL single_count: got %0d expected 1", rxCount); end
    rxReady = 1'b1;
    @(negedge clkB);
    rxReady = 1'b0;
    nChecks++; if (fifoLevel !== 3'd0) begin nFails++; $display("FAIL single_drain: got %0d expected 0", fifoLevel); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit allOk;
    applyReset();
    allOk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sharedBus = 64'(i);
      busReq    = 1'b1;
      waitAck(1'b1, 3, ok);
      if (!ok) allOk = 1'b0;
      busReq = 1'b0;
      waitAck(1'b0, 3, ok);
      if (!ok) allOk = 1'b0;
    end
    nChecks++; if (!allOk) begin nFails++; $display("FAIL bp_four_acks: got a missing ack expected all 4 acked"); end
    nChecks++; if (fifoLevel !== 3'd4) begin nFails++; $display("FAIL bp_level_full: got %0d expected 4", fifoLevel); end
    sharedBus = 64'd5;
    busReq    = 1'b1;
    repeat (6) @(negedge clkB);
    nChecks++; if (busAck !== 1'b0) begin nFails++; $display("FAIL bp_held_off: got %b expected 0", busAck); end
    rxReady = 1'b1;
    @(negedge clkB);
    rxReady = 1'b0;
    waitAck(1'b1, 3, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL bp_fifth_ack: got %b expected 1", busAck); end
    nChecks++; if (fifoLevel !== 3'd4) begin nFails++; $display("FAIL bp_level_after: got %0d expected 4", fifoLevel); end
    nChecks++; if (rxData !== 64'd2) begin nFails++; $display("FAIL bp_head: got %0d expected 2", rxData); end
    busReq = 1'b0;
    waitAck(1'b0, 3, ok);
    rxReady = 1'b1;
    repeat (4) @(negedge clkB);
    rxReady = 1'b0;
    nChecks++; if (fifoLevel !== 3'd0) begin nFails++; $display("FAIL bp_drained: got %0d expected 0", fifoLevel); end
  endtask

  task automatic test_order_wrap();
    bit ok;
    applyReset();
    rxReady = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      sharedBus = 64'(i);
      busReq    = 1'b1;
      waitAck(1'b1, 3, ok);
      nChecks++; if (!ok || rxData !== 64'(i)) begin nFails++; $display("FAIL order_word%0d: got %0d (ack %b) expected %0d", i, rxData, busAck, i); end
      busReq = 1'b0;
      waitAck(1'b0, 3, ok);
    end
    rxReady = 1'b0;
    nChecks++; if (fifoLevel !== 3'd0) begin nFails++; $display("FAIL order_level: got %0d expected 0", fifoLevel); end
    nChecks++; if (rxCount !== 16'd10) begin nFails++; $display("FAIL order_count: got %0d expected 10", rxCount); end
  endtask

  task automatic test_midop_reset();
    bit ok;
    applyReset();
    sharedBus = 64'hAA;
    busReq    = 1'b1;
    waitAck(1'b1, 3, ok);
    nChecks++; if (!ok || fifoLevel !== 3'd1) begin nFails++; $display("FAIL midrst_pre: got ack %b level %0d expected ack 1 level 1", busAck, fifoLevel); end
    rst = 1'b0;
    @(negedge clkB);
    nChecks++; if (busAck !== 1'b0) begin nFails++; $display("FAIL midrst_ack: got %b expected 0", busAck); end
    nChecks++; if (fifoLevel !== 3'd0) begin nFails++; $display("FAIL midrst_level: got %0d expected 0", fifoLevel); end
    sharedBus = 64'hBB;
    rst       = 1'b1;
    waitAck(1'b1, 4, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL midrst_recapture: got %b expected 1", busAck); end
    nChecks++; if (rxCount !== 16'd1) begin nFails++; $display("FAIL midrst_count: got %0d expected 1", rxCount); end
    nChecks++; if (rxData !== 64'hBB) begin nFails++; $display("FAIL midrst_data: got %h expected bb", rxData); end
    busReq = 1'b0;
    waitAck(1'b0, 3, ok);
  endtask

`ifdef HS_RX_PARITY_EN
  task automatic test_parity();
    bit ok;
    applyReset();
    nChecks++; if (parityErr !== 1'b0) begin nFails++; $display("FAIL parity_reset: got %b expected 0", parityErr); end
    sharedBus = 64'h1;
    busParity = 1'b0;
    busReq    = 1'b1;
    waitAck(1'b1, 3, ok);
    nChecks++; if (!ok) begin nFails++; $display("FAIL parity_ack: got %b expected 1", busAck); end
    nChecks++; if (parityErr !== 1'b1) begin nFails++; $display("FAIL parity_set: got %b expected 1", parityErr); end
    busReq = 1'b0;
    waitAck(1'b0, 3, ok);
    sharedBus = 64'h3;
    busReq    = 1'b1;
    waitAck(1'b1, 3, ok);
    nChecks++; if (!ok || parityErr !== 1'b1) begin nFails++; $display("FAIL parity_sticky: got ack %b err %b expected 1 1", busAck, parityErr); end
    busReq = 1'b0;
    waitAck(1'b0, 3, ok);
  endtask
`endif

  initial begin
    rst       = 1'b0;
    busReq    = 1'b0;
    rxReady   = 1'b0;
    sharedBus = '0;
`ifdef HS_RX_PARITY_EN
    busParity = 1'b0;
`endif
    test_reset();
    test_single_xfer();
    test_backpressure();
    test_order_wrap();
    test_midop_reset();
`ifdef HS_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
